// File: rtl/srambank_ctrl_512x74.sv
`default_nettype none
// ==== srambank_ctrl_512x74 : read / masked-write front end for the 512x74 SRAM bank ====
// ==== partial writes run as read-modify-write; 2-entry response FIFO    (rev 1.0) ====
module srambank_ctrl_512x74 #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 74,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] wd,
  output logic              banksel,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] dataout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  state_t              state;
  logic                rd_pending;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mask_q;

  logic [DATA_W-1:0]   buf_q [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;

  logic                accept;
  logic                full_wr;
  logic                push;
  logic                pop;
  logic [2:0]          occ;

  assign rsp_valid = (count != 2'd0);
  assign rsp_rdata = buf_q[rd_ptr];
  assign pop       = rsp_valid & rsp_ready;
  assign push      = rd_pending;

  // Occupancy once this cycle settles: a read may only issue if its data has a slot.
  assign occ       = {1'b0, count} + {2'b00, rd_pending} - {2'b00, pop};
  assign req_ready = rst_n & (state == IDLE) & (occ < 3'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign full_wr   = &req_wmask;

  always_comb begin
    read    = 1'b0;
    write   = 1'b0;
    ADDRESS = '0;
    wd      = '0;
    if (state == MERGE) begin
      write   = 1'b1;
      ADDRESS = addr_q;
      wd      = (dataout & ~mask_q) | (wdata_q & mask_q);
    end else if (accept) begin
      ADDRESS = req_addr;
      if (req_write && full_wr) begin
        write = 1'b1;
        wd    = req_wdata;
      end else begin
        read = 1'b1;
      end
    end
  end

  assign banksel = read | write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_pending <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
    end else begin
      rd_pending <= accept & ~req_write;
      case (state)
        IDLE: begin
          if (accept && req_write && !full_wr) begin
            state   <= MERGE;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            mask_q  <= req_wmask;
          end
        end
        MERGE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= dataout;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire
